// File: rtl/tt_acc_alu.sv
// Registered add/sub/accumulate/clear datapath core with valid/ready handshake,
// optional unsigned saturation, status flags and a wrapping transaction counter.
module tt_acc_alu #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             sat,
  output logic             zero,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             sat_r;
  logic             zero_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] txn_count_r;

  logic             accept_s;
  logic             consume_s;
  logic [WIDTH:0]   raw_s;
  logic             carry_s;
  logic [WIDTH-1:0] res_s;
  logic             sat_s;
  logic             acc_load_s;

  // The single-entry result buffer can take a new op whenever it is empty or being drained.
  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign consume_s = out_valid_r && out_ready;
  assign acc_load_s = accept_s && ((op == OP_ACC) || (op == OP_CLR));

  // Raw WIDTH+1-bit arithmetic; bit WIDTH is carry for add/acc and borrow for sub.
  always_comb begin
    raw_s   = {(WIDTH+1){1'b0}};
    carry_s = 1'b0;
    case (op)
      OP_ADD: begin
        raw_s   = {1'b0, a} + {1'b0, b};
        carry_s = raw_s[WIDTH];
      end
      OP_SUB: begin
        raw_s   = {1'b0, a} - {1'b0, b};
        carry_s = raw_s[WIDTH];
      end
      OP_ACC: begin
        raw_s   = {1'b0, acc_r} + {1'b0, a};
        carry_s = raw_s[WIDTH];
      end
      OP_CLR: begin
        raw_s   = {(WIDTH+1){1'b0}};
        carry_s = 1'b0;
      end
      default: begin
        raw_s   = {(WIDTH+1){1'b0}};
        carry_s = 1'b0;
      end
    endcase
  end

  // Saturation clamps toward the bound that was crossed: zero on borrow, all ones on carry.
  always_comb begin
    res_s = raw_s[WIDTH-1:0];
    sat_s = 1'b0;
    if ((SATURATE != 0) && carry_s) begin
      sat_s = 1'b1;
      if (op == OP_SUB) begin
        res_s = {WIDTH{1'b0}};
      end else begin
        res_s = {WIDTH{1'b1}};
      end
    end else begin
      res_s = raw_s[WIDTH-1:0];
      sat_s = 1'b0;
    end
  end

  // Result buffer, flags, accumulator and transaction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      sat_r       <= 1'b0;
      zero_r      <= 1'b0;
      acc_r       <= {WIDTH{1'b0}};
      txn_count_r <= {CNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        result_r    <= res_s;
        carry_r     <= carry_s;
        sat_r       <= sat_s;
        zero_r      <= (res_s == {WIDTH{1'b0}});
        txn_count_r <= txn_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (consume_s) begin
        out_valid_r <= 1'b0;
      end
      if (acc_load_s) begin
        acc_r <= res_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign carry     = carry_r;
  assign sat       = sat_r;
  assign zero      = zero_r;
  assign acc       = acc_r;
  assign txn_count = txn_count_r;

endmodule

// File: doc/tt_acc_alu.md
Name: tt_acc_alu

Overview:
- Parametrised, registered successor to the team's combinational 8-bit adder tile.
- Performs add, subtract, accumulate or clear on operand pairs behind a valid/ready handshake, with one result register and a persistent accumulator.
- Adds optional unsigned saturation, status flags and a transaction counter.
- Sits between the tile's input pins and output pins as the datapath core of the next tile revision.

Parameters:
WIDTH, 8, operand/result/accumulator width in bits (>=2)
SATURATE, 1, 1 = unsigned saturation on overflow/borrow; 0 = modulo-2^WIDTH wrap
CNT_W, 8, width of transaction counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand/op presented
in_ready  out  1  block can accept this cycle
op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
a  in  WIDTH  operand A
b  in  WIDTH  operand B (ignored for ACC/CLR)
out_valid  out  1  result register holds unconsumed result
out_ready  in  1  consumer takes result this cycle
result  out  WIDTH  registered result
carry  out  1  registered carry-out (ADD/ACC) or borrow (SUB) of the raw WIDTH+1-bit operation
sat  out  1  registered: result was clamped (only possible when SATURATE=1)
zero  out  1  registered: result == 0
acc  out  WIDTH  current accumulator value
txn_count  out  CNT_W  accepted transactions, wraps

Behaviour:
- Reset (asynchronous, any time, including mid-handshake): result, carry, sat, zero, acc, txn_count = 0; out_valid = 0. zero is 0 in reset, not 1; flags are only meaningful with out_valid. The pending result is discarded.
- in_ready = !out_valid || out_ready. Combinational, no dependence on in_valid.
- Accept = in_valid && in_ready. Latency 1: the accepted op's result appears in result/flags with out_valid=1 on the next edge.
- Consume = out_valid && out_ready.
  - Consume without accept: out_valid clears at the edge; result and flags hold their last values.
  - Consume with accept in the same cycle: the new result replaces the old one and out_valid stays 1, giving full throughput of 1 op/cycle.
- While out_valid && !out_ready: result, flags and acc are frozen; in_ready = 0.
- Arithmetic uses a WIDTH+1-bit raw value:
  - ADD: raw = a + b; carry = raw[WIDTH].
  - SUB: raw = a - b; carry = borrow (a < b).
  - ACC: raw = acc + a; carry = raw[WIDTH]. acc <= final result.
  - CLR: result = 0, acc <= 0, carry = 0, sat = 0.
- SATURATE=1:
  - ADD/ACC with carry: result = all ones, sat = 1.
  - SUB with borrow: result = 0, sat = 1.
  - Otherwise sat = 0.
- SATURATE=0: result = raw[WIDTH-1:0]; sat = 0; carry still reported.
- acc changes only on accepted ACC or CLR; ADD and SUB never touch it.
- zero reflects the final (post-saturation) result.
- txn_count increments by 1 on every accept regardless of op; wraps from 2^CNT_W-1 to 0.
- No internal FSM beyond the out_valid full/empty bit. The result register is a single-entry buffer: empty (out_valid=0) and full (out_valid=1) states, with transitions as above.

Test Plan (WIDTH=8, CNT_W=8):
1. Reset, then ADD a=8'h12 b=8'h34 with out_ready=1 -> next cycle out_valid=1, result=8'h46, carry=0, sat=0, zero=0, txn_count=1.
2. SATURATE=1: ADD a=8'hF0 b=8'h20 -> result=8'hFF, carry=1, sat=1. SUB a=8'h05 b=8'h09 -> result=8'h00, carry=1, sat=1, zero=1. Repeat with SATURATE=0 -> results 8'h10 and 8'hFC, sat=0, carry=1.
3. CLR, then ACC a=8'h64 three times (SATURATE=1) -> results 8'h64, 8'hC8, 8'hFF (sat=1); acc=8'hFF. A following ADD 1+1 leaves acc=8'hFF.
4. Backpressure: accept ADD 1+2, hold out_ready=0 for 3 cycles with in_valid=1 and a new op -> in_ready=0, result stays 8'h03, txn_count stays 1. Raise out_ready -> the new op is accepted that cycle and its result appears on the next edge.
5. Streaming: in_valid=1 and out_ready=1 for 300 consecutive ADD ops -> one result per cycle, out_valid never drops, txn_count wraps to 300 mod 256 = 44.
6. Assert rst mid-stream while out_valid=1 and acc=8'h55 -> all outputs 0 immediately, before the next edge. After release, in_ready=1 and the first op is accepted normally.
